jump_target_pipe: RTL and testbench
===================================

// Module: jump_target_pipe
// PURPOSE
//   Parametrised next-PC target generator for the fetch stage. Selects one of four targets:
//   sequential, J-type region jump, PC-relative branch or register jump. Region jump is
//   {PC+4 upper bits, index, zero alignment bits}.
//   Result is registered behind a valid/ready handshake with a 2-entry skid buffer, giving
//   1-cycle latency and full throughput between decode and the PC register.
// PARAMETERS
//   ADDR_W     32  address width; must satisfy ADDR_W > INDEX_W + ALIGN_BITS
//   INDEX_W    26  J-type instruction index width
//   OFF_W      16  branch offset width (signed, in instruction words)
//   ALIGN_BITS  2  log2(instruction bytes); low bits forced/checked zero
// PORTS
//   Clk            in   1          rising-edge clock
//   Reset          in   1          synchronous, active-high reset
//   in_valid       in   1          request present
//   in_ready       out  1          block can accept request this cycle
//   mode           in   2          00 SEQ, 01 JUMP, 10 BRANCH, 11 JREG
//   branch_taken   in   1          BRANCH only: 0 -> behaves as SEQ
//   pc_plus4       in   ADDR_W     address of following instruction
//   jump_index     in   INDEX_W    J-type index field
//   branch_off     in   OFF_W      signed word offset
//   reg_target     in   ADDR_W     rs value for JREG
//   out_valid      out  1          target_addr valid
//   out_ready      in   1          consumer accepts this cycle
//   target_addr    out  ADDR_W     computed next PC
//   misalign       out  1          target low ALIGN_BITS nonzero (MISALIGN_CHECK_EN only)
// BEHAVIOUR
//   - Reset (sync, Reset=1 at posedge): out_valid=0, target_addr=0, misalign=0, in_ready=1,
//     skid cleared. Any request held in the block is discarded, including mid-stall.
//   - Target arithmetic (combinational, on inputs):
//       SEQ    : pc_plus4
//       JUMP   : {pc_plus4[ADDR_W-1:INDEX_W+ALIGN_BITS], jump_index, ALIGN_BITS'b0}
//       BRANCH : taken ? pc_plus4 + (sext(branch_off) << ALIGN_BITS) : pc_plus4
//       JREG   : reg_target
//     Sums wrap modulo 2^ADDR_W; no overflow flag.
//   - Transfers: input on in_valid & in_ready; output on out_valid & out_ready.
//   - Latency: an accepted request appears on target_addr the next cycle.
//   - Order is preserved. Outputs are held stable while out_valid & !out_ready.
//   - Occupancy states:
//       EMPTY (out_valid=0):
//         accept -> ONE.
//       ONE (output reg full, skid empty):
//         accept & drain -> ONE, new value.
//         accept & !drain -> FULL; new value goes to skid.
//         drain only -> EMPTY.
//       FULL (output reg and skid full; in_ready=0):
//         drain -> ONE; skid moves to output reg.
//   - in_ready is a register: 1 in EMPTY/ONE, 0 in FULL. It never depends
//     combinationally on out_ready.
//   - Simultaneous accept+drain in ONE sustains 1 transfer/cycle indefinitely.
//   - in_valid with in_ready=0 is ignored; the upstream must hold the request.
// CONFIGURATION
//   MISALIGN_CHECK_EN defined:
//     - misalign registered alongside target_addr; 1 when JREG target low ALIGN_BITS != 0.
//       The address is passed through unmodified.
//     - misalign is carried through the skid with its entry.
//   MISALIGN_CHECK_EN undefined:
//     - misalign tied 0.
//     - JREG target low ALIGN_BITS are forced to 0.
// TESTING
//   1 Reset held 3 cycles mid-FULL -> next cycle out_valid=0, in_ready=1, target_addr=0.
//   2 JUMP pc_plus4=0x9000_0004, jump_index=0x0123456, out_ready=1 -> next cycle
//     target_addr=0x9048_D158.
//   3 BRANCH taken pc_plus4=0x0000_0010, branch_off=0xFFFC -> 0x0000_0000.
//     Same with pc_plus4=0xFFFF_FFF0, off=0x0008 -> 0x0000_0010 (wrap).
//   4 out_ready=0, two requests A,B -> in_ready=0 after B, A held stable.
//     Release out_ready -> A then B on consecutive cycles, in order.
//   5 Back-to-back 100 mixed-mode requests, out_ready=1 -> 1 result/cycle, all match model.
//   6 JREG reg_target=0x0040_0006 -> CHECK_EN: target 0x0040_0006, misalign=1.
//     Without CHECK_EN: target 0x0040_0004, misalign=0.

Source files
------------

// File: rtl/jump_target_pipe.sv
// Next-PC target generator (SEQ / JUMP / BRANCH / JREG) registered behind a
// 2-entry skid buffer. Optional `MISALIGN_CHECK_EN` flags unaligned JREG targets.
module jump_target_pipe #(
  parameter int ADDR_W     = 32,
  parameter int INDEX_W    = 26,
  parameter int OFF_W      = 16,
  parameter int ALIGN_BITS = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        mode,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic [INDEX_W-1:0] jump_index,
  input  logic [OFF_W-1:0]  branch_off,
  input  logic [ADDR_W-1:0] reg_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] target_addr,
  output logic              misalign,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] MODE_SEQ    = 2'b00;
  localparam logic [1:0] MODE_JUMP   = 2'b01;
  localparam logic [1:0] MODE_BRANCH = 2'b10;
  localparam logic [1:0] MODE_JREG   = 2'b11;

  // Handshake: a request transfers on in_valid & in_ready, a result on
  // out_valid & out_ready. in_ready is registered and never looks at out_ready.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_e;

  occ_state_e        state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              out_mis_q, out_mis_d;
  logic [ADDR_W-1:0] skid_addr_q, skid_addr_d;
  logic              skid_mis_q, skid_mis_d;

  logic [ADDR_W-1:0] jump_addr;
  logic [ADDR_W-1:0] branch_disp;
  logic [ADDR_W-1:0] branch_addr;
  logic [ADDR_W-1:0] jreg_addr;
  logic              jreg_mis;
  logic [ADDR_W-1:0] new_addr;
  logic              new_mis;
  logic              accept;
  logic              drain;

  assign jump_addr   = {pc_plus4[ADDR_W-1:INDEX_W+ALIGN_BITS], jump_index, {ALIGN_BITS{1'b0}}};
  assign branch_disp = {{(ADDR_W-OFF_W){branch_off[OFF_W-1]}}, branch_off} << ALIGN_BITS;
  assign branch_addr = pc_plus4 + branch_disp;

`ifdef MISALIGN_CHECK_EN
  assign jreg_addr = reg_target;
  assign jreg_mis  = |reg_target[ALIGN_BITS-1:0];
`else
  // Without the check, an unaligned register target is silently aligned down.
  assign jreg_addr = {reg_target[ADDR_W-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
  assign jreg_mis  = 1'b0;
`endif

  always_comb begin
    new_addr = pc_plus4;
    new_mis  = 1'b0;
    unique case (mode)
      MODE_SEQ:    new_addr = pc_plus4;
      MODE_JUMP:   new_addr = jump_addr;
      MODE_BRANCH: new_addr = branch_taken ? branch_addr : pc_plus4;
      MODE_JREG: begin
        new_addr = jreg_addr;
        new_mis  = jreg_mis;
      end
    endcase
  end

  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid & in_ready_q;
  assign drain     = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    out_addr_d  = out_addr_q;
    out_mis_d   = out_mis_q;
    skid_addr_d = skid_addr_q;
    skid_mis_d  = skid_mis_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          out_addr_d = new_addr;
          out_mis_d  = new_mis;
          state_d    = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          out_addr_d = new_addr;
          out_mis_d  = new_mis;
        end else if (accept) begin
          skid_addr_d = new_addr;
          skid_mis_d  = new_mis;
          state_d     = ST_FULL;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (drain) begin
          out_addr_d = skid_addr_q;
          out_mis_d  = skid_mis_q;
          state_d    = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_addr_q  <= '0;
      out_mis_q   <= 1'b0;
      skid_addr_q <= '0;
      skid_mis_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_addr_q  <= out_addr_d;
      out_mis_q   <= out_mis_d;
      skid_addr_q <= skid_addr_d;
      skid_mis_q  <= skid_mis_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign target_addr = out_addr_q;
  assign misalign    = out_mis_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_jump_target_pipe.sv
// Directed bench for jump_target_pipe; expectations follow `MISALIGN_CHECK_EN when defined.
module tb_jump_target_pipe;

  logic        Clk;
  logic        Reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  mode;
  logic        branch_taken;
  logic [31:0] pc_plus4;
  logic [25:0] jump_index;
  logic [15:0] branch_off;
  logic [31:0] reg_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] target_addr;
  logic        misalign;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic        exp_mis_q[$];

  jump_target_pipe dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .branch_taken(branch_taken), .pc_plus4(pc_plus4),
    .jump_index(jump_index), .branch_off(branch_off), .reg_target(reg_target),
    .out_valid(out_valid), .out_ready(out_ready), .target_addr(target_addr),
    .misalign(misalign), .dbg_state(dbg_state)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model
  function automatic logic [31:0] model_addr(input logic [1:0] m, input logic tk,
      input logic [31:0] pc, input logic [25:0] idx, input logic [15:0] off,
      input logic [31:0] rt);
    logic [31:0] soff;
    soff = 32'($signed(off));
    case (m)
      2'b00: return pc;
      2'b01: return (pc & 32'hF000_0000) | ({6'd0, idx} * 32'd4);
      2'b10: return tk ? pc + soff * 32'd4 : pc;
      default: begin
`ifdef MISALIGN_CHECK_EN
        return rt;
`else
        return rt & 32'hFFFF_FFFC;
`endif
      end
    endcase
  endfunction

  function automatic logic model_mis(input logic [1:0] m, input logic [31:0] rt);
`ifdef MISALIGN_CHECK_EN
    return (m == 2'b11) && (rt % 4 != 0);
`else
    return 1'b0 & m[0] & rt[0];
`endif
  endfunction

  // driver
  task automatic set_req(input logic [1:0] m, input logic tk, input logic [31:0] pc,
      input logic [25:0] idx, input logic [15:0] off, input logic [31:0] rt);
    in_valid     = 1'b1;
    mode         = m;
    branch_taken = tk;
    pc_plus4     = pc;
    jump_index   = idx;
    branch_off   = off;
    reg_target   = rt;
    exp_q.push_back(model_addr(m, tk, pc, idx, off, rt));
    exp_mis_q.push_back(model_mis(m, rt));
  endtask

  task automatic check_head(input string tag);
    logic [31:0] ea;
    logic        em;
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_underflow"}, 32'd0, 32'd1);
    end else begin
      ea = exp_q.pop_front();
      em = exp_mis_q.pop_front();
      check({tag, "_addr"}, target_addr, ea);
      check({tag, "_mis"}, {31'd0, misalign}, {31'd0, em});
    end
  endtask

  task automatic fill_two();
    out_ready = 1'b0;
    set_req(2'b00, 1'b0, 32'h0000_1000, 26'd0, 16'd0, 32'd0);
    step();
    set_req(2'b00, 1'b0, 32'h0000_2000, 26'd0, 16'd0, 32'd0);
    step();
    in_valid = 1'b0;
  endtask

  logic [1:0]  r_m;
  logic [31:0] r_pc, r_rt;
  logic [25:0] r_idx;
  logic [15:0] r_off;
  logic        r_tk;

  initial begin
    Reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = 2'b00;
    branch_taken = 1'b0; pc_plus4 = '0; jump_index = '0; branch_off = '0; reg_target = '0;
    step(); step();
    Reset = 1'b0;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_target", target_addr, 32'd0);
    check("rst_misalign", {31'd0, misalign}, 32'd0);

    // Reset held 3 cycles while FULL
    fill_two();
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    Reset = 1'b1;
    step(); step(); step();
    Reset = 1'b0;
    exp_q.delete(); exp_mis_q.delete();
    check("rstfull_out_valid", {31'd0, out_valid}, 32'd0);
    check("rstfull_in_ready", {31'd0, in_ready}, 32'd1);
    check("rstfull_target", target_addr, 32'd0);
    out_ready = 1'b1;
    step();
    check("rstfull_still_empty", {31'd0, out_valid}, 32'd0);

    // JUMP
    set_req(2'b01, 1'b0, 32'h9000_0004, 26'h0123456, 16'd0, 32'd0);
    step(); in_valid = 1'b0;
    check("jump_const", target_addr, 32'h9048_D158);
    check_head("jump");
    // BRANCH negative and wrap
    set_req(2'b10, 1'b1, 32'h0000_0010, 26'd0, 16'hFFFC, 32'd0);
    step(); in_valid = 1'b0;
    check("br_neg_const", target_addr, 32'h0000_0000);
    check_head("br_neg");
    set_req(2'b10, 1'b1, 32'hFFFF_FFF0, 26'd0, 16'h0008, 32'd0);
    step(); in_valid = 1'b0;
    check("br_wrap_const", target_addr, 32'h0000_0010);
    check_head("br_wrap");
    set_req(2'b10, 1'b0, 32'h0000_0400, 26'd0, 16'h0008, 32'd0);
    step(); in_valid = 1'b0;
    check("br_nt_const", target_addr, 32'h0000_0400);
    check_head("br_nt");
    // JREG misaligned
    set_req(2'b11, 1'b0, 32'h0000_0000, 26'd0, 16'd0, 32'h0040_0006);
    step(); in_valid = 1'b0;
`ifdef MISALIGN_CHECK_EN
    check("jreg_const", target_addr, 32'h0040_0006);
    check("jreg_mis_const", {31'd0, misalign}, 32'd1);
`else
    check("jreg_const", target_addr, 32'h0040_0004);
    check("jreg_mis_const", {31'd0, misalign}, 32'd0);
`endif
    check_head("jreg");
    step();
    check("idle_empty", {31'd0, out_valid}, 32'd0);

    // Stall: A then B, then release
    out_ready = 1'b0;
    set_req(2'b00, 1'b0, 32'h0000_A000, 26'd0, 16'd0, 32'd0);
    step();
    check("stall_a_addr", target_addr, 32'h0000_A000);
    check("stall_a_ready", {31'd0, in_ready}, 32'd1);
    set_req(2'b01, 1'b0, 32'h1000_0000, 26'h0000_B00, 16'd0, 32'd0);
    step(); in_valid = 1'b0;
    check("stall_b_ready", {31'd0, in_ready}, 32'd0);
    check("stall_a_held", target_addr, 32'h0000_A000);
    check("stall_state", {30'd0, dbg_state}, 32'd2);
    // Ignored request while not ready
    in_valid = 1'b1; mode = 2'b00; pc_plus4 = 32'hDEAD_0000;
    step(); in_valid = 1'b0;
    check("stall_a_held2", target_addr, 32'h0000_A000);
    check("stall_valid", {31'd0, out_valid}, 32'd1);
    check_head("stall_a");
    out_ready = 1'b1;
    step();
    check_head("stall_b");
    check("stall_b_addr_const", target_addr, 32'h1000_2C00);
    check("release_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("release_empty", {31'd0, out_valid}, 32'd0);

    // 100 back-to-back mixed-mode requests
    for (int i = 0; i < 100; i++) begin
      r_m   = 2'($urandom_range(0, 3));
      r_tk  = 1'($urandom_range(0, 1));
      r_pc  = $urandom();
      r_idx = 26'($urandom());
      r_off = 16'($urandom());
      r_rt  = $urandom();
      set_req(r_m, r_tk, r_pc, r_idx, r_off, r_rt);
      step();
      check_head("stream");
      check("stream_ready", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    check("stream_drained", {31'd0, out_valid}, 32'd0);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
